ss_disp_arb: RTL and testbench

SS_DISP_ARB -- requirements
Module: ss_disp_arb

---
 rtl/ss_arb_pkg.sv | 37 +++
 rtl/ss_disp_arb_tick_gen.sv | 28 ++
 rtl/ss_disp_arb.sv | 117 +++++++++++
 tb/tb_ss_disp_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ss_arb_pkg.sv
// Shared types and helpers for the display arbiter.
// Round-robin pick and one-hot encode for three requesters.
package ss_arb_pkg;

    localparam int N_REQ = 3;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OWN
    } state_t;

    // First set bit strictly after 'from', wrapping 2->0.
    function automatic logic [1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [1:0]       from
    );
        logic [1:0] idx;
        logic       hit;
        rr_pick = from;
        hit     = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = 2'((int'(from) + i) % N_REQ);
            if (!hit && req[idx]) begin
                rr_pick = idx;
                hit     = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
        onehot = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/ss_disp_arb_tick_gen.sv
// Free-running prescaler: one-clock tick every 'divider' clocks.
// Counter restarts from zero on reset.
module tick_gen #(
    parameter int divider = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (divider > 1) ? $clog2(divider) : 1;
    localparam logic [W-1:0] LAST = W'(divider - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ss_disp_arb.sv
// Round-robin arbiter sharing one 4-digit display among three requesters.
// A new owner keeps the display for HOLD_TICKS ticks before it can be preempted.
module ss_disp_arb
    import ss_arb_pkg::*;
#(
    parameter int          divider    = 5000000,
    parameter int          HOLD_TICKS = 4,
    parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [15:0]      data0,
    input  logic [15:0]      data1,
    input  logic [15:0]      data2,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0,
    output logic             busy
);

    localparam logic [7:0] HOLD_LD = 8'(HOLD_TICKS);

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [N_REQ-1:0] others;
    logic [7:0]       hold_cnt, hold_n;
    logic [1:0]       last_owner, last_n;
    logic [1:0]       pick;
    logic             tick;
    word_t            word, disp;

    tick_gen #(
        .divider(divider)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            hold_cnt   <= '0;
            last_owner <= 2'd2;
            disp       <= IDLE_WORD;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            hold_cnt   <= hold_n;
            last_owner <= last_n;
            disp       <= word;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        hold_n  = hold_cnt;
        last_n  = last_owner;
        others  = req & ~gnt;
        pick    = '0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    pick    = rr_pick(req, last_owner);
                    gnt_n   = onehot(pick);
                    last_n  = pick;
                    hold_n  = HOLD_LD;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    hold_n = hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        state_n = OWN;
                    end
                end
            end
            OWN: begin
                // last_owner always names the current owner here
                if (|others) begin
                    pick    = rr_pick(others, last_owner);
                    gnt_n   = onehot(pick);
                    last_n  = pick;
                    hold_n  = HOLD_LD;
                    state_n = HOLD;
                end else if (!(|req)) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        word = IDLE_WORD;
        unique case (1'b1)
            gnt[0]:  word = data0;
            gnt[1]:  word = data1;
            gnt[2]:  word = data2;
            default: word = IDLE_WORD;
        endcase
    end

    assign {d3, d2, d1, d0} = disp;
    assign busy             = |gnt;

endmodule

// File: tb/tb_ss_disp_arb.sv
// Randomized bench for ss_disp_arb against a behavioural ownership model.
// Directed phases cover first grant, hold, preemption, drop and reset.
module tb_ss_disp_arb;

    localparam int DIV = 2;
    localparam int HT  = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req   = '0;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic [15:0] data2 = '0;
    logic [2:0]  gnt;
    logic [3:0]  d3, d2, d1, d0;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    int          m_owner = -1;
    int          m_left  = 0;
    int          m_last  = 2;
    int          m_edge  = 0;
    bit          m_own   = 1'b0;
    logic [15:0] m_disp  = '0;

    always #5 clk = ~clk;

    ss_disp_arb #(
        .divider   (DIV),
        .HOLD_TICKS(HT),
        .IDLE_WORD (16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .data0(data0),
        .data1(data1),
        .data2(data2),
        .gnt  (gnt),
        .d3   (d3),
        .d2   (d2),
        .d1   (d1),
        .d0   (d0),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        case (i)
            0:       return data0;
            1:       return data1;
            2:       return data2;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int next_owner(input logic [2:0] r, input int from);
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (from + i) % 3;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = 2;
        m_edge  = 0;
        m_own   = 1'b0;
        m_disp  = 16'h0000;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_step();
        bit          tk;
        logic [2:0]  oth;
        logic [15:0] nd;
        tk = (m_edge % DIV) == DIV - 1;
        m_edge++;
        nd = (m_owner < 0) ? 16'h0000 : word_of(m_owner);
        if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = next_owner(req, m_last);
                m_last  = m_owner;
                m_left  = HT;
                m_own   = 1'b0;
            end
        end else if (!m_own) begin
            if (tk) begin
                if (m_left == 1) m_own = 1'b1;
                m_left--;
            end
        end else begin
            oth = req & ~(3'(1) << m_owner);
            if (oth != 0) begin
                m_owner = next_owner(oth, m_owner);
                m_last  = m_owner;
                m_left  = HT;
                m_own   = 1'b0;
            end else if (req == 0) begin
                m_owner = -1;
            end
        end
        m_disp = nd;
    endtask

    task automatic cmp();
        logic [2:0] eg;
        eg = (m_owner < 0) ? 3'b000 : 3'(1) << m_owner;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(eg != 0));
        chk("disp", 32'({d3, d2, d1, d0}), 32'(m_disp));
    endtask

    task automatic cycle(input logic [2:0] r);
        req = r;
        model_step();
        @(negedge clk);
        cmp();
    endtask

    initial begin
        int         q_idx[$];
        int         q_cyc[$];
        logic [2:0] prev;
        logic [2:0] r;
        bit         hit;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_disp", 32'({d3, d2, d1, d0}), 32'h0);
        rst_n = 1'b1;

        repeat (6) cycle(3'b000);
        chk("idle_gnt", 32'(gnt), 32'h0);

        data0 = 16'hF730;
        cycle(3'b001);
        chk("first_gnt", 32'(gnt), 32'h1);
        cycle(3'b001);
        chk("first_disp", 32'({d3, d2, d1, d0}), 32'hF730);
        repeat (12) cycle(3'b001);
        chk("own_keep", 32'(gnt), 32'h1);

        repeat (2) cycle(3'b000);
        chk("own_drop", 32'(gnt), 32'h0);
        chk("own_drop_disp", 32'({d3, d2, d1, d0}), 32'h0);

        cycle(3'b001);
        repeat (3) cycle(3'b011);
        chk("hold_block", 32'(gnt), 32'h1);
        repeat (5) cycle(3'b011);
        chk("preempt", 32'(gnt), 32'h2);
        cycle(3'b000);
        chk("hold_drop", 32'(gnt), 32'h2);
        repeat (8) cycle(3'b000);
        chk("drop_idle", 32'(gnt), 32'h0);
        chk("drop_disp", 32'({d3, d2, d1, d0}), 32'h0);

        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle(3'b111);
            if (m_owner == 2 && !m_own) hit = 1'b1;
        end
        chk("find_hold2", 32'(hit), 32'h1);
        if (hit) begin
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_gnt", 32'(gnt), 32'h0);
            chk("mid_rst_busy", 32'(busy), 32'h0);
            chk("mid_rst_disp", 32'({d3, d2, d1, d0}), 32'h0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
        end

        prev = 3'b000;
        for (int i = 0; i < 40; i++) begin
            cycle(3'b111);
            if (gnt != prev && gnt != 0) begin
                q_idx.push_back(idx_of(gnt));
                q_cyc.push_back(i);
            end
            prev = gnt;
        end
        chk("n_grants", 32'(q_idx.size() >= 4), 32'h1);
        if (q_idx.size() >= 4) begin
            chk("order0", 32'(q_idx[0]), 32'd0);
            chk("order1", 32'(q_idx[1]), 32'd1);
            chk("order2", 32'(q_idx[2]), 32'd2);
            chk("order3", 32'(q_idx[3]), 32'd0);
            for (int k = 1; k < 4; k++) begin
                int iv;
                iv = q_cyc[k] - q_cyc[k-1];
                chk("interval", 32'(iv >= 6 && iv <= 7), 32'h1);
            end
        end

        for (int i = 0; i < 1500; i++) begin
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            data2 = 16'($urandom);
            r = req;
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
